// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: alignment check, one variable-latency bus access per
// request with lane enables and replicated store data, right-aligned load response.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT   = 255,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_sel,
    output logic        rsp_sign,
    output logic [4:0]  rsp_rd,
    output logic        rsp_we,
    output logic        misalign,
    output logic        bus_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // Last count value before expiry: the MAX_WAIT-th BUS cycle is the expiry cycle.
    localparam logic [15:0] LAST_CNT = 16'(MAX_WAIT - 1);

    state_t      state_reg;
    logic [15:0] wait_cnt_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        sign_reg;
    logic [4:0]  rd_reg;
    logic [1:0]  off_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] mem_wdata_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;
    logic [2:0]  rsp_sel_reg;
    logic        rsp_sign_reg;
    logic [4:0]  rsp_rd_reg;
    logic        rsp_we_reg;
    logic        misalign_reg;
    logic        bus_err_reg;

    logic        illegal;
    logic [1:0]  lane_off;
    logic [3:0]  lane_be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;
    logic [2:0]  sel_code;

    // Request decode: legality, lane offset, byte enables and replicated store data.
    always_comb begin
        illegal   = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        lane_off  = 2'b00;
        lane_be   = 4'b1111;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                lane_off  = BIG_ENDIAN ? 2'd3 - req_addr[1:0] : req_addr[1:0];
                lane_be   = 4'b0001 << lane_off;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_off  = BIG_ENDIAN ? 2'd2 - req_addr[1:0] : req_addr[1:0];
                lane_be   = 4'b0011 << lane_off;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load data is right-aligned from the captured lane and cut to the access size.
    always_comb begin
        rdata_shift = mem_rdata >> {off_reg, 3'b000};
        load_data   = rdata_shift;
        sel_code    = 3'b000;
        case (size_reg)
            2'b00: begin
                load_data = {24'h0, rdata_shift[7:0]};
                sel_code  = 3'b010;
            end
            2'b01: begin
                load_data = {16'h0, rdata_shift[15:0]};
                sel_code  = 3'b001;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 16'h0;
            we_reg        <= 1'b0;
            size_reg      <= 2'b00;
            sign_reg      <= 1'b0;
            rd_reg        <= 5'h0;
            off_reg       <= 2'b00;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'h0;
            mem_be_reg    <= 4'h0;
            mem_wdata_reg <= 32'h0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'h0;
            rsp_sel_reg   <= 3'b000;
            rsp_sign_reg  <= 1'b0;
            rsp_rd_reg    <= 5'h0;
            rsp_we_reg    <= 1'b0;
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            misalign_reg <= 1'b1;
                        end else begin
                            we_reg        <= req_we;
                            size_reg      <= req_size;
                            sign_reg      <= req_sign;
                            rd_reg        <= req_rd;
                            off_reg       <= lane_off;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= req_we;
                            mem_addr_reg  <= {req_addr[31:2], 2'b00};
                            mem_be_reg    <= lane_be;
                            mem_wdata_reg <= req_we ? wdata_rep : 32'h0;
                            wait_cnt_reg  <= 16'h0;
                            state_reg     <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (mem_ack || wait_cnt_reg == LAST_CNT) begin
                        mem_req_reg   <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= 32'h0;
                        mem_be_reg    <= 4'h0;
                        mem_wdata_reg <= 32'h0;
                    end
                    // An ack on the expiry cycle still completes the access.
                    if (mem_ack) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= we_reg ? 32'h0 : load_data;
                        rsp_sel_reg   <= sel_code;
                        rsp_sign_reg  <= sign_reg & ~we_reg;
                        rsp_rd_reg    <= rd_reg;
                        rsp_we_reg    <= ~we_reg;
                        state_reg     <= RESP;
                    end else if (wait_cnt_reg == LAST_CNT) begin
                        bus_err_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'h1;
                    end
                end
                RESP: begin
                    rsp_data_reg <= 32'h0;
                    rsp_sel_reg  <= 3'b000;
                    rsp_sign_reg <= 1'b0;
                    rsp_rd_reg   <= 5'h0;
                    rsp_we_reg   <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_sel   = rsp_sel_reg;
    assign rsp_sign  = rsp_sign_reg;
    assign rsp_rd    = rsp_rd_reg;
    assign rsp_we    = rsp_we_reg;
    assign misalign  = misalign_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a little-endian and a big-endian instance share stimulus;
// a byte-address memory model supplies every expected lane, enable and load value.
module tb_mem_access_unit;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        req_ready_o [2];
    logic        mem_req_o   [2];
    logic        mem_we_o    [2];
    logic [31:0] mem_addr_o  [2];
    logic [3:0]  mem_be_o    [2];
    logic [31:0] mem_wdata_o [2];
    logic        rsp_valid_o [2];
    logic [31:0] rsp_data_o  [2];
    logic [2:0]  rsp_sel_o   [2];
    logic        rsp_sign_o  [2];
    logic [4:0]  rsp_rd_o    [2];
    logic        rsp_we_o    [2];
    logic        misalign_o  [2];
    logic        bus_err_o   [2];
    logic        busy_o      [2];

    logic [3:0]  last_be  [2];
    logic [31:0] last_rsp [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0 is little-endian, instance 1 big-endian.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_access_unit #(.MAX_WAIT(MW), .BIG_ENDIAN(gi == 1)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid), .req_ready(req_ready_o[gi]),
            .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
            .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
            .mem_req(mem_req_o[gi]), .mem_we(mem_we_o[gi]), .mem_addr(mem_addr_o[gi]),
            .mem_be(mem_be_o[gi]), .mem_wdata(mem_wdata_o[gi]),
            .mem_ack(mem_ack), .mem_rdata(mem_rdata),
            .rsp_valid(rsp_valid_o[gi]), .rsp_data(rsp_data_o[gi]), .rsp_sel(rsp_sel_o[gi]),
            .rsp_sign(rsp_sign_o[gi]), .rsp_rd(rsp_rd_o[gi]), .rsp_we(rsp_we_o[gi]),
            .misalign(misalign_o[gi]), .bus_err(bus_err_o[gi]), .busy(busy_o[gi])
        );
    end

    // ---------------- reference model (byte-address view of a 32-bit word) ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_legal(input logic [1:0] size, input logic [31:0] addr);
        return (size != 2'b11) && ((addr % nbytes(size)) == 0);
    endfunction

    // Bit lane (0..3) that holds memory byte address a within the word.
    function automatic int lane_of(input int big, input int a);
        return big ? 3 - (a % 4) : (a % 4);
    endfunction

    function automatic logic [3:0] model_be(input int big, input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be = 4'h0;
        for (int k = 0; k < nbytes(size); k++)
            be[lane_of(big, int'(addr[1:0]) + k)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_load(input int big, input logic [1:0] size,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v = 32'h0;
        int n = nbytes(size);
        for (int k = 0; k < n; k++) begin
            logic [31:0] b = 32'(rdata[8*lane_of(big, int'(addr[1:0]) + k) +: 8]);
            v = v | (big ? (b << (8*(n-1-k))) : (b << (8*k)));
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'b00) return 32'(w[7:0]) * 32'h01010101;
        if (size == 2'b01) return 32'(w[15:0]) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [2:0] model_sel(input logic [1:0] size);
        return (size == 2'b00) ? 3'b010 : (size == 2'b01) ? 3'b001 : 3'b000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One access from an idle unit. ack_at = BUS cycle in which mem_ack is driven (0 = never).
    task automatic run_access(input logic we, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                              input int ack_at, input logic [31:0] rdata, input bit noise, input int id);
        int  fails0;
        bit  done;
        fails0 = failures;
        done = 0;
        if (noise) begin
            mem_ack = 1'b1;
            mem_rdata = rdata;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("idle_ack_rsp_valid[%0d]", i), 32'(rsp_valid_o[i]), 32'h0);
                chk($sformatf("idle_ack_busy[%0d]", i), 32'(busy_o[i]), 32'h0);
            end
            mem_ack = 1'b0;
        end
        for (int i = 0; i < 2; i++)
            chk($sformatf("req_ready_before[%0d]", i), 32'(req_ready_o[i]), 32'h1);
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (!is_legal(size, addr)) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("misalign[%0d]", i), 32'(misalign_o[i]), 32'h1);
                chk($sformatf("misalign_mem_req[%0d]", i), 32'(mem_req_o[i]), 32'h0);
                chk($sformatf("misalign_ready[%0d]", i), 32'(req_ready_o[i]), 32'h1);
                last_be[i] = mem_be_o[i];
                last_rsp[i] = rsp_data_o[i];
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("misalign_pulse_end[%0d]", i), 32'(misalign_o[i]), 32'h0);
                chk($sformatf("misalign_no_req[%0d]", i), 32'(mem_req_o[i]), 32'h0);
            end
        end else begin
            for (int n = 1; n <= MW && !done; n++) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("bus_mem_req[%0d]", i), 32'(mem_req_o[i]), 32'h1);
                    chk($sformatf("bus_mem_we[%0d]", i), 32'(mem_we_o[i]), 32'(we));
                    chk($sformatf("bus_mem_addr[%0d]", i), mem_addr_o[i], addr & 32'hFFFF_FFFC);
                    chk($sformatf("bus_mem_be[%0d]", i), 32'(mem_be_o[i]), 32'(model_be(i, size, addr)));
                    chk($sformatf("bus_busy[%0d]", i), 32'(busy_o[i]), 32'h1);
                    chk($sformatf("bus_ready[%0d]", i), 32'(req_ready_o[i]), 32'h0);
                    chk($sformatf("bus_rsp_valid[%0d]", i), 32'(rsp_valid_o[i]), 32'h0);
                    if (we) chk($sformatf("bus_mem_wdata[%0d]", i), mem_wdata_o[i], model_wdata(size, wdata));
                    if (n == 1) last_be[i] = mem_be_o[i];
                end
                if (n == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                    for (int i = 0; i < 2; i++) begin
                        chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid_o[i]), 32'h1);
                        chk($sformatf("rsp_we[%0d]", i), 32'(rsp_we_o[i]), 32'(!we));
                        chk($sformatf("rsp_rd[%0d]", i), 32'(rsp_rd_o[i]), 32'(rd));
                        chk($sformatf("rsp_data[%0d]", i), rsp_data_o[i],
                            we ? 32'h0 : model_load(i, size, addr, rdata));
                        chk($sformatf("rsp_mem_req_low[%0d]", i), 32'(mem_req_o[i]), 32'h0);
                        chk($sformatf("rsp_mem_be_low[%0d]", i), 32'(mem_be_o[i]), 32'h0);
                        if (!we) begin
                            chk($sformatf("rsp_sel[%0d]", i), 32'(rsp_sel_o[i]), 32'(model_sel(size)));
                            chk($sformatf("rsp_sign[%0d]", i), 32'(rsp_sign_o[i]), 32'(sign));
                        end
                        last_rsp[i] = rsp_data_o[i];
                    end
                    @(negedge clk);
                    for (int i = 0; i < 2; i++) begin
                        chk($sformatf("rsp_pulse_end[%0d]", i), 32'(rsp_valid_o[i]), 32'h0);
                        chk($sformatf("post_rsp_ready[%0d]", i), 32'(req_ready_o[i]), 32'h1);
                    end
                    done = 1;
                end else begin
                    @(negedge clk);
                    if (n == MW) begin
                        for (int i = 0; i < 2; i++) begin
                            chk($sformatf("bus_err[%0d]", i), 32'(bus_err_o[i]), 32'h1);
                            chk($sformatf("err_mem_req[%0d]", i), 32'(mem_req_o[i]), 32'h0);
                            chk($sformatf("err_rsp_valid[%0d]", i), 32'(rsp_valid_o[i]), 32'h0);
                            chk($sformatf("err_ready[%0d]", i), 32'(req_ready_o[i]), 32'h1);
                            last_rsp[i] = rsp_data_o[i];
                        end
                        @(negedge clk);
                        for (int i = 0; i < 2; i++) begin
                            chk($sformatf("bus_err_end[%0d]", i), 32'(bus_err_o[i]), 32'h0);
                            chk($sformatf("err_no_rsp[%0d]", i), 32'(rsp_valid_o[i]), 32'h0);
                        end
                        done = 1;
                    end
                end
            end
        end
        $display("txn %0d we=%0d size=%0d addr=0x%08h ack_at=%0d -> %s", id, we, size, addr, ack_at,
                 (failures == fails0) ? "ok" : "bad");
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          ack_at;
        logic [31:0] rdata;
        logic [3:0]  exp_be_le;
        logic [31:0] exp_rsp_le;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1, 3, 32'h0,        4'b1111, 32'h0};
        vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h203, 32'h0,        5'd2, 1, 32'h80112233, 4'b1000, 32'h80};
        vecs[2] = '{1'b1, 2'b01, 1'b0, 32'h0A,  32'h1234,     5'd3, 1, 32'h0,        4'b1100, 32'h0};
        vecs[3] = '{1'b0, 2'b01, 1'b0, 32'h101, 32'h0,        5'd4, 1, 32'h0,        4'b0000, 32'h0};
        vecs[4] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        5'd5, 1, 32'h0,        4'b0000, 32'h0};
        vecs[5] = '{1'b0, 2'b11, 1'b0, 32'h0,   32'h0,        5'd6, 1, 32'h0,        4'b0000, 32'h0};
        vecs[6] = '{1'b0, 2'b10, 1'b0, 32'h04,  32'h0,        5'd7, 4, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 2'b01, 1'b1, 32'h06,  32'h0,        5'd8, 2, 32'hAABBCCDD, 4'b1100, 32'hAABB};
        vecs[8] = '{1'b0, 2'b00, 1'b0, 32'h01,  32'h0,        5'd9, 1, 32'h11223344, 4'b0010, 32'h33};
        vecs[9] = '{1'b1, 2'b00, 1'b0, 32'h03,  32'h5A,       5'd10, 0, 32'h0,       4'b1000, 32'h0};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_ready[%0d]", i), 32'(req_ready_o[i]), 32'h1);
            chk($sformatf("reset_mem_req[%0d]", i), 32'(mem_req_o[i]), 32'h0);
            chk($sformatf("reset_mem_be[%0d]", i), 32'(mem_be_o[i]), 32'h0);
            chk($sformatf("reset_busy[%0d]", i), 32'(busy_o[i]), 32'h0);
            chk($sformatf("reset_rsp_valid[%0d]", i), 32'(rsp_valid_o[i]), 32'h0);
            chk($sformatf("reset_misalign[%0d]", i), 32'(misalign_o[i]), 32'h0);
            chk($sformatf("reset_bus_err[%0d]", i), 32'(bus_err_o[i]), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            run_access(vecs[v].we, vecs[v].size, vecs[v].sign, vecs[v].addr, vecs[v].wdata,
                       vecs[v].rd, vecs[v].ack_at, vecs[v].rdata, 1'b0, v);
            chk($sformatf("tbl%0d_be_le", v), 32'(last_be[0]), 32'(vecs[v].exp_be_le));
            chk($sformatf("tbl%0d_rsp_le", v), last_rsp[0], vecs[v].exp_rsp_le);
        end

        // Halfword store in big-endian lands in the low lanes.
        run_access(1'b1, 2'b01, 1'b0, 32'h0A, 32'h1234, 5'd11, 1, 32'h0, 1'b0, 100);
        chk("sh_be_mem_be", 32'(last_be[1]), 32'h3);

        // Async reset during BUS, then a late ack that must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40; req_rd = 5'd12;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++)
            chk($sformatf("pre_reset_mem_req[%0d]", i), 32'(mem_req_o[i]), 32'h1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("async_mem_req[%0d]", i), 32'(mem_req_o[i]), 32'h0);
            chk($sformatf("async_busy[%0d]", i), 32'(busy_o[i]), 32'h0);
            chk($sformatf("async_ready[%0d]", i), 32'(req_ready_o[i]), 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("late_ack_rsp_valid[%0d]", i), 32'(rsp_valid_o[i]), 32'h0);
            chk($sformatf("late_ack_mem_req[%0d]", i), 32'(mem_req_o[i]), 32'h0);
        end
        run_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 5'd13, 2, 32'h0BADF00D, 1'b0, 101);

        // Randomized traffic, including illegal sizes, misalignment, timeouts and idle acks.
        for (int r = 0; r < 60; r++) begin
            logic [1:0]  size;
            logic [31:0] addr;
            size = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(size) - 1);
            run_access(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
                       5'($urandom_range(0, 31)), int'($urandom_range(0, 5)), $urandom,
                       ($urandom_range(0, 3) == 0), 200 + r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
